bfly_stage_sequencer: RTL and testbench
=======================================

BFLY_STAGE_SEQUENCER -- requirements
Module: bfly_stage_sequencer

Interface
REQ-001 Parameter NUM, default 16, words per phase; power of two, >= 2.
REQ-002 Parameter PHASES, default 4, phases per frame; even, >= 2.
REQ-003 Parameter MUL_LAT, default 1, cycles from bfly_add_sub_en to bfly_mul_en; range 1..4.
REQ-004 clk  input  1  clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 valid_in  input  1  one input word accepted this cycle.
REQ-007 sync_clr  input  1  synchronous restart of the sequence.
REQ-008 bfly_add_sub_en  output  1  add/sub butterfly stage enable.
REQ-009 bfly_mul_en  output  1  twiddle-multiply stage enable.
REQ-010 phase  output  $clog2(PHASES)  current phase index (shift type).
REQ-011 idx  output  $clog2(NUM)  word index within the current phase.
REQ-012 frame_done  output  1  single-cycle pulse at frame end.

Function
REQ-013 All outputs SHALL be registered; no combinational path from input to output.
REQ-014 advance SHALL equal valid_in in even phases and 1 in odd phases, so odd (butterfly) phases are self-timed and drain without valid_in.
REQ-015 On a clock with advance=1 and idx<NUM-1, idx SHALL increment by 1; with advance=0, idx and phase SHALL hold.
REQ-016 On a clock with advance=1 and idx==NUM-1, idx SHALL become 0 and phase SHALL become (phase+1) mod PHASES.
REQ-017 bfly_add_sub_en SHALL be 1 exactly while phase is odd, and SHALL update on the same edge as phase.
REQ-018 bfly_mul_en SHALL equal bfly_add_sub_en delayed by exactly MUL_LAT clocks, independent of valid_in.
REQ-019 frame_done SHALL be 1 for exactly one cycle, on the cycle after phase wraps from PHASES-1 to 0.
REQ-020 One frame SHALL take NUM*PHASES advances; consecutive frames SHALL run back-to-back with no idle cycle.
REQ-021 sync_clr=1 SHALL, on the next edge, set idx, phase, bfly_add_sub_en, frame_done and the whole mul delay line to 0.
REQ-022 sync_clr SHALL take priority over valid_in and over the internal advance in the same cycle.
REQ-023 valid_in during an odd phase SHALL NOT cause a double step; idx SHALL advance by at most 1 per clock.
REQ-024 The delay line SHALL keep shifting during a valid_in gap, so bfly_mul_en trails bfly_add_sub_en by MUL_LAT clocks even after bfly_add_sub_en falls.

Reset
REQ-025 While rst=0, every output and internal register SHALL be 0, asynchronously.
REQ-026 After rst is released, the first accepted valid_in SHALL be counted as idx 0 of phase 0.
REQ-027 Assertion of rst during an odd phase SHALL drop both enables within the same cycle and SHALL NOT emit frame_done.

Structure
REQ-028 Package fft_ctrl_pkg SHALL hold the phase index typedef, the width helper constants and the MUL_LAT bound check.
REQ-029 One sub-module, en_delay_line, SHALL implement the MUL_LAT-deep enable shift register, with rst and sync_clr.
REQ-030 Illegal parameters (NUM not a power of two, odd PHASES, MUL_LAT outside 1..4) SHALL fail at elaboration.

Verification
REQ-031 Reset: rst=0 with valid_in toggling -> all outputs 0; after release with no valid_in -> idx=0, phase=0 held.
REQ-032 NUM=4, PHASES=4, MUL_LAT=1, continuous valid_in:
  - bfly_add_sub_en high for 4 cycles starting after the 4th accepted word, then low for 4 cycles, then high for 4.
  - bfly_mul_en shows the same pattern 1 cycle later.
  - frame_done pulses after 16 advances.
REQ-033 Fill-phase gaps: valid_in pattern 1,0,1,0,1,1 in phase 0 -> idx steps 0,1,1,2,2,3; phase becomes 1 after the last word.
REQ-034 Butterfly-phase drain: valid_in dropped to 0 on the first cycle of phase 1 -> phase 1 completes in 4 cycles, then phase=2 and idx stays 0 until valid_in returns.
REQ-035 sync_clr asserted at phase=1, idx=2, with valid_in=1 -> next cycle all outputs 0; bfly_mul_en stays 0, no residual pulse; recount starts from idx 0.
REQ-036 MUL_LAT=3 build, continuous valid_in -> bfly_mul_en rises exactly 3 cycles after bfly_add_sub_en and falls 3 cycles after it; back-to-back frames show no idle cycle.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared FFT control definitions: phase index type, width helpers and
// elaboration-time parameter checks used by the stage sequencer.
package fft_ctrl_pkg;

  localparam int DEF_NUM     = 16;
  localparam int DEF_PHASES  = 4;
  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 4;

  localparam int DEF_IDX_W   = $clog2(DEF_NUM);
  localparam int DEF_PHASE_W = $clog2(DEF_PHASES);

  typedef logic [DEF_PHASE_W-1:0] phase_idx_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit mul_lat_ok(input int lat);
    return (lat >= MUL_LAT_MIN) && (lat <= MUL_LAT_MAX);
  endfunction

endpackage

// File: rtl/en_delay_line.sv
// Fixed-depth enable shift register; clears on async reset or sync_clr.
module en_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] taps;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps <= '0;
    end else if (sync_clr) begin
      taps <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/bfly_stage_sequencer.sv
// FFT stage sequencer: even phases fill on valid_in, odd (butterfly)
// phases run self-timed; the multiply enable trails by MUL_LAT clocks.
module bfly_stage_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int NUM     = DEF_NUM,
  parameter int PHASES  = DEF_PHASES,
  parameter int MUL_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic                      sync_clr,
  output logic                      bfly_add_sub_en,
  output logic                      bfly_mul_en,
  output logic [$clog2(PHASES)-1:0] phase,
  output logic [$clog2(NUM)-1:0]    idx,
  output logic                      frame_done
);

  localparam int IW = $clog2(NUM);
  localparam int PW = $clog2(PHASES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASES - 1);

  if (!is_pow2(NUM) || NUM < 2) begin : g_bad_num
    $error("bfly_stage_sequencer: NUM must be a power of two >= 2");
  end
  if ((PHASES % 2) != 0 || PHASES < 2) begin : g_bad_phases
    $error("bfly_stage_sequencer: PHASES must be even and >= 2");
  end
  if (!mul_lat_ok(MUL_LAT)) begin : g_bad_lat
    $error("bfly_stage_sequencer: MUL_LAT must be within 1..4");
  end

  logic          advance;
  logic          idx_wrap;
  logic          phase_wrap;
  logic [IW-1:0] idx_next;
  logic [PW-1:0] phase_next;

  // Odd phases always advance so the butterfly pass drains without input.
  always_comb begin
    advance    = phase[0] | valid_in;
    idx_wrap   = (idx == IDX_LAST);
    phase_wrap = (phase == PHASE_LAST);
    idx_next   = idx_wrap ? '0 : idx + 1'b1;
    phase_next = phase;
    if (idx_wrap) begin
      phase_next = phase_wrap ? '0 : phase + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx             <= '0;
      phase           <= '0;
      bfly_add_sub_en <= 1'b0;
      frame_done      <= 1'b0;
    end else if (sync_clr) begin
      idx             <= '0;
      phase           <= '0;
      bfly_add_sub_en <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      frame_done <= advance & idx_wrap & phase_wrap;
      if (advance) begin
        idx             <= idx_next;
        phase           <= phase_next;
        bfly_add_sub_en <= phase_next[0];
      end
    end
  end

  en_delay_line #(
    .DEPTH(MUL_LAT)
  ) u_mul_dly (
    .clk      (clk),
    .rst      (rst),
    .sync_clr (sync_clr),
    .d        (bfly_add_sub_en),
    .q        (bfly_mul_en)
  );

endmodule

// File: tb/tb_bfly_stage_sequencer.sv
// Bench for bfly_stage_sequencer: NUM=4, PHASES=4 with MUL_LAT 1 and 3,
// checked against an advance-count model plus hand-computed points.
module tb_bfly_stage_sequencer;

  localparam int NUM    = 4;
  localparam int PHASES = 4;
  localparam int FRAME  = NUM * PHASES;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_in = 1'b0;
  logic       sync_clr = 1'b0;

  logic       as_a, mul_a, fd_a;
  logic [1:0] phase_a, idx_a;
  logic       as_b, mul_b, fd_b;
  logic [1:0] phase_b, idx_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bfly_stage_sequencer #(.NUM(NUM), .PHASES(PHASES), .MUL_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sync_clr(sync_clr),
    .bfly_add_sub_en(as_a), .bfly_mul_en(mul_a), .phase(phase_a),
    .idx(idx_a), .frame_done(fd_a)
  );

  bfly_stage_sequencer #(.NUM(NUM), .PHASES(PHASES), .MUL_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sync_clr(sync_clr),
    .bfly_add_sub_en(as_b), .bfly_mul_en(mul_b), .phase(phase_b),
    .idx(idx_b), .frame_done(fd_b)
  );

  // Model: position in the frame as a plain advance count; everything
  // else is derived from it arithmetically.
  int       m_cnt = 0;
  logic     m_fd = 1'b0;
  logic [7:0] m_hist = '0;
  int       m_phase, m_idx;
  logic     m_as, m_adv;

  always_comb begin
    m_phase = (m_cnt / NUM) % PHASES;
    m_idx   = m_cnt % NUM;
    m_as    = (m_phase % 2) == 1;
    m_adv   = m_as || valid_in;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt  <= 0;
      m_fd   <= 1'b0;
      m_hist <= '0;
    end else if (sync_clr) begin
      m_cnt  <= 0;
      m_fd   <= 1'b0;
      m_hist <= '0;
    end else begin
      m_hist <= {m_hist[6:0], m_as};
      if (m_adv) begin
        m_cnt <= (m_cnt == FRAME - 1) ? 0 : m_cnt + 1;
        m_fd  <= (m_cnt == FRAME - 1);
      end else begin
        m_fd <= 1'b0;
      end
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check_output("cmp_idx_a",   idx_a,   m_idx);
    check_output("cmp_phase_a", phase_a, m_phase);
    check_output("cmp_as_a",    as_a,    m_as);
    check_output("cmp_fd_a",    fd_a,    m_fd);
    check_output("cmp_mul_a",   mul_a,   m_hist[0]);
    check_output("cmp_idx_b",   idx_b,   m_idx);
    check_output("cmp_phase_b", phase_b, m_phase);
    check_output("cmp_as_b",    as_b,    m_as);
    check_output("cmp_fd_b",    fd_b,    m_fd);
    check_output("cmp_mul_b",   mul_b,   m_hist[2]);
  end

  task automatic apply_stimulus(input logic v, input logic c);
    @(negedge clk);
    valid_in = v;
    sync_clr = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit vpat[6] = '{1, 0, 1, 0, 1, 1};
    int ipat[6] = '{0, 1, 1, 2, 2, 3};

    // Reset held with valid_in toggling: everything stays at zero.
    for (int i = 0; i < 4; i++) apply_stimulus(i[0], 1'b0);
    check_output("rst_idx",   idx_a,   0);
    check_output("rst_phase", phase_a, 0);
    check_output("rst_as",    as_a,    0);
    check_output("rst_mul",   mul_b,   0);
    check_output("rst_fd",    fd_a,    0);

    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    check_output("idle_idx",   idx_a,   0);
    check_output("idle_phase", phase_a, 0);

    // Fill phase with gaps.
    for (int i = 0; i < 6; i++) begin
      check_output("fill_idx", idx_a, ipat[i]);
      apply_stimulus(vpat[i], 1'b0);
    end
    check_output("fill_phase1", phase_a, 1);
    check_output("fill_idx0",   idx_a,   0);
    check_output("fill_as",     as_a,    1);

    // Butterfly phase drains with valid_in low, then phase 2 waits.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0);
    check_output("drain_phase2", phase_a, 2);
    check_output("drain_as",     as_a,    0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0);
    check_output("wait_idx",   idx_a,   0);
    check_output("wait_phase", phase_a, 2);
    for (int k = 1; k <= 8; k++) apply_stimulus(1'b1, 1'b0);
    check_output("wrap_phase", phase_a, 0);
    check_output("wrap_fd",    fd_a,    1);

    // Continuous frame: enable pattern and multiply lag for both builds.
    for (int k = 1; k <= 17; k++) begin
      apply_stimulus(1'b1, 1'b0);
      case (k)
        1:  check_output("cont_fd_single", fd_a, 0);
        3:  check_output("cont_as_e3", as_a, 0);
        4:  begin check_output("cont_as_e4", as_a, 1); check_output("cont_mul1_e4", mul_a, 0); end
        5:  check_output("cont_mul1_e5", mul_a, 1);
        6:  check_output("cont_mul3_e6", mul_b, 0);
        7:  begin check_output("cont_as_e7", as_a, 1); check_output("cont_mul3_e7", mul_b, 1); end
        8:  begin check_output("cont_as_e8", as_a, 0); check_output("cont_mul1_e8", mul_a, 1); end
        9:  check_output("cont_mul1_e9", mul_a, 0);
        10: check_output("cont_mul3_e10", mul_b, 1);
        11: check_output("cont_mul3_e11", mul_b, 0);
        12: check_output("cont_as_e12", as_b, 1);
        16: begin check_output("cont_fd_e16", fd_b, 1); check_output("cont_phase_e16", phase_a, 0); end
        17: begin check_output("b2b_idx", idx_a, 1); check_output("b2b_fd", fd_a, 0); end
        default: ;
      endcase
    end

    // sync_clr mid butterfly phase with valid_in high.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0);
    check_output("pre_clr_phase", phase_a, 1);
    check_output("pre_clr_idx",   idx_a,   2);
    apply_stimulus(1'b1, 1'b1);
    check_output("clr_idx",   idx_a,   0);
    check_output("clr_phase", phase_a, 0);
    check_output("clr_as",    as_a,    0);
    check_output("clr_mul_a", mul_a,   0);
    check_output("clr_mul_b", mul_b,   0);
    for (int j = 0; j < 3; j++) begin
      apply_stimulus(1'b1, 1'b0);
      if (j == 0) check_output("recount_idx", idx_a, 1);
      check_output("post_clr_mul_a", mul_a, 0);
      check_output("post_clr_mul_b", mul_b, 0);
    end

    // Async reset during an odd phase.
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    check_output("pre_rst_as",  as_a,  1);
    check_output("pre_rst_mul", mul_a, 1);
    rst = 1'b0;
    #1;
    check_output("arst_as_a",  as_a,    0);
    check_output("arst_as_b",  as_b,    0);
    check_output("arst_mul_a", mul_a,   0);
    check_output("arst_fd",    fd_a,    0);
    check_output("arst_phase", phase_a, 0);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    check_output("arst_hold_idx", idx_a, 0);
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    apply_stimulus(1'b1, 1'b0);
    check_output("first_word_idx", idx_a, 1);

    // Mixed traffic with one restart, checked by the model only.
    for (int i = 0; i < 60; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'(i == 37));
    end
    apply_stimulus(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
